// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the FSM state encoding, the opcode/funct constants that make up the
// supported instruction subset (ld, sd, add/sub/and/or, beq), the ALUOp and
// ALU B-operand select codes, the Moore control-word type, and a helper that
// maps a state to its Moore control word.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_RWB,
    S_BRANCH,
    S_TRAP
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // funct3 values of the supported instructions
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;

  // ALUOp field (upper two bits of the ALU-control word)
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Outputs that depend on state only
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic       fault;
  } ctrl_t;

  // States that hold a memory request open
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // Moore control word for a state. funct7b5/funct3 only matter in EXECUTE.
  function automatic ctrl_t moore_ctrl(input state_t s, input logic funct7b5,
                                       input logic [2:0] funct3);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = {ALUOP_MEM, 4'b0000};
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = {ALUOP_MEM, 4'b0000};
      end
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = {ALUOP_MEM, 4'b0000};
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = {ALUOP_RTYPE, funct7b5, funct3};
      end
      S_RWB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = {ALUOP_BRANCH, 4'b0000};
        c.pc_src    = 1'b1;
      end
      S_TRAP: begin
        c.fault = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational next-state decode for the multicycle control FSM.
// Checks instruction legality from opcode/funct3/funct7b5 and selects the
// next state from the current state, memory handshake and timeout flag.
// Ports:
//   state      current FSM state
//   opcode     IR opcode
//   funct3     IR funct3
//   funct7b5   IR bit 30
//   mem_ready  memory completes the open request this cycle
//   timeout    wait counter has reached its limit
//   next_state state to load at the next clock edge
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       mem_ready,
  input  logic       timeout,
  output state_t     next_state
);

  logic is_ld;
  logic is_sd;
  logic is_rtype;
  logic is_beq;

  assign is_ld  = (opcode == OP_LD) && (funct3 == F3_DWORD);
  assign is_sd  = (opcode == OP_SD) && (funct3 == F3_DWORD);
  assign is_beq = (opcode == OP_BEQ) && (funct3 == F3_BEQ);
  // add and sub share funct3; and/or are only legal with funct7b5 clear
  assign is_rtype = (opcode == OP_RTYPE) &&
                    ((funct3 == F3_ADD_SUB) ||
                     (!funct7b5 && ((funct3 == F3_AND) || (funct3 == F3_OR))));

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    next_state = S_FETCH;
      S_FETCH: begin
        // a completing handshake takes priority over the timeout
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) next_state = S_TRAP;
      end
      S_DECODE: begin
        if (is_ld || is_sd) next_state = S_MEMADDR;
        else if (is_rtype)  next_state = S_EXECUTE;
        else if (is_beq)    next_state = S_BRANCH;
        else                next_state = S_TRAP;
      end
      S_MEMADDR: next_state = is_sd ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    next_state = S_MEMWB;
        else if (timeout) next_state = S_TRAP;
      end
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)    next_state = S_FETCH;
        else if (timeout) next_state = S_TRAP;
      end
      S_EXECUTE: next_state = S_RWB;
      S_RWB:     next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit for ld, sd, add, sub, and, or, beq.
// A single FSM sequences fetch/decode/execute; state-only outputs are
// registered alongside the state, while IR/PC write strobes that depend on
// the memory handshake or the zero flag are decoded combinationally.
// A saturating wait counter traps requests left unanswered too long.
// Parameter:
//   TIMEOUT_CYCLES  wait cycles allowed before a memory fault; 0 disables
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_opcode, i_funct3,
//   i_funct7b5           instruction fields from IR
//   i_zero               ALU zero flag
//   i_mem_ready          memory completes the current request
//   o_mem_req, o_mem_we,
//   o_iord               memory request, write, address select
//   o_ir_write,
//   o_pc_write, o_pc_src IR/PC load controls
//   o_reg_write,
//   o_mem_to_reg         register write-back controls
//   o_alu_src_a,
//   o_alu_src_b, o_alu_op ALU operand selects and ALU-control word
//   o_fault              sticky fault (illegal instruction or timeout)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_src,
  output logic       o_reg_write,
  output logic       o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [5:0] o_alu_op,
  output logic       o_fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  state_t           next_state;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  assign timeout = (TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_LIMIT);

  control_decode u_decode (
    .state      (state),
    .opcode     (i_opcode),
    .funct3     (i_funct3),
    .funct7b5   (i_funct7b5),
    .mem_ready  (i_mem_ready),
    .timeout    (timeout),
    .next_state (next_state)
  );

  // State, registered Moore outputs (decoded from the state being entered so
  // they line up with it) and the wait counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      ctrl_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= moore_ctrl(next_state, i_funct7b5, i_funct3);
      if (is_mem_state(next_state) && (next_state != state)) begin
        wait_cnt <= '0;
      end else if (is_mem_state(state) && !i_mem_ready && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign o_mem_req    = ctrl_q.mem_req;
  assign o_mem_we     = ctrl_q.mem_we;
  assign o_iord       = ctrl_q.iord;
  assign o_pc_src     = ctrl_q.pc_src;
  assign o_reg_write  = ctrl_q.reg_write;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_alu_src_a  = ctrl_q.alu_src_a;
  assign o_alu_src_b  = ctrl_q.alu_src_b;
  assign o_alu_op     = ctrl_q.alu_op;
  assign o_fault      = ctrl_q.fault;

  // Strobes that follow the handshake / zero flag within the cycle
  assign o_ir_write = (state == S_FETCH) && i_mem_ready;
  assign o_pc_write = ((state == S_FETCH) && i_mem_ready) ||
                      ((state == S_BRANCH) && i_zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control (TIMEOUT_CYCLES = 4). Each instruction is
// expanded into the per-cycle list of control words the unit must produce,
// with random memory wait counts, and every cycle is compared.
module tb_multicycle_control;

  localparam int TO = 4;

  localparam int K_LD  = 0;
  localparam int K_SD  = 1;
  localparam int K_R   = 2;
  localparam int K_BEQ = 3;
  localparam int K_ILL = 4;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic       i_funct7b5 = 1'b0;
  logic       i_zero = 1'b0;
  logic       i_mem_ready = 1'b0;
  logic       o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write, o_pc_src;
  logic       o_reg_write, o_mem_to_reg, o_alu_src_a, o_fault;
  logic [1:0] o_alu_src_b;
  logic [5:0] o_alu_op;
  logic [17:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_opcode     (i_opcode),
    .i_funct3     (i_funct3),
    .i_funct7b5   (i_funct7b5),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_iord       (o_iord),
    .o_ir_write   (o_ir_write),
    .o_pc_write   (o_pc_write),
    .o_pc_src     (o_pc_src),
    .o_reg_write  (o_reg_write),
    .o_mem_to_reg (o_mem_to_reg),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (o_alu_op),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  assign obs = {o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write, o_pc_src,
                o_reg_write, o_mem_to_reg, o_alu_src_a, o_alu_src_b, o_alu_op, o_fault};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] mk(input bit mr, input bit we, input bit io,
                                     input bit irw, input bit pcw, input bit pcs,
                                     input bit rw, input bit m2r, input bit sa,
                                     input logic [1:0] sb, input logic [5:0] op,
                                     input bit f);
    return {mr, we, io, irw, pcw, pcs, rw, m2r, sa, sb, op, f};
  endfunction

  // Instruction class from the supported-subset rules
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3,
                                  input logic f7);
    if (op == 7'b0000011 && f3 == 3'b011) return K_LD;
    if (op == 7'b0100011 && f3 == 3'b011) return K_SD;
    if (op == 7'b0110011 && (f3 == 3'b000 || (!f7 && (f3 == 3'b111 || f3 == 3'b110))))
      return K_R;
    if (op == 7'b1100011 && f3 == 3'b000) return K_BEQ;
    return K_ILL;
  endfunction

  // Check outputs mid-cycle, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [17:0] exp);
    @(negedge clk);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
      $error("check %s", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ready();
    i_mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_seq();
    i_rst = 1'b1;
    rand_ready();
    @(posedge clk);
    #1;
    step("reset_hold", '0);
    i_rst = 1'b0;
    step("reset_idle", '0);
  endtask

  task automatic trap_and_reset(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      rand_ready();
      step({tag, "_trap"}, mk(0,0,0,0,0,0,0,0,0,2'b00,6'b0,1));
    end
    reset_seq();
  endtask

  // A request may go unanswered for at most TO cycles; more than that traps.
  task automatic mem_phase(input string tag, input int waits,
                           input logic [17:0] e_wait, input logic [17:0] e_done,
                           output bit trapped);
    trapped = (waits > TO);
    for (int i = 0; i < waits && i <= TO; i++) begin
      i_mem_ready = 1'b0;
      step({tag, "_wait"}, e_wait);
    end
    if (!trapped) begin
      i_mem_ready = 1'b1;
      step(tag, e_done);
    end
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op,
                           input logic [2:0] f3, input logic f7, input logic z,
                           input int wf, input int wm);
    bit tr;
    int kind;
    logic [17:0] e_memread;
    logic [17:0] e_memwrite;
    i_opcode   = op;
    i_funct3   = f3;
    i_funct7b5 = f7;
    i_zero     = z;
    kind       = classify(op, f3, f7);
    e_memread  = mk(1,0,1,0,0,0,0,0,0,2'b00,6'b0,0);
    e_memwrite = mk(1,1,1,0,0,0,0,0,0,2'b00,6'b0,0);
    mem_phase({tag, "_fetch"}, wf, mk(1,0,0,0,0,0,0,0,0,2'b01,6'b0,0),
              mk(1,0,0,1,1,0,0,0,0,2'b01,6'b0,0), tr);
    if (tr) begin
      trap_and_reset({tag, "_fetch_to"}, 3);
      return;
    end
    rand_ready();
    step({tag, "_decode"}, mk(0,0,0,0,0,0,0,0,0,2'b10,6'b0,0));
    case (kind)
      K_LD, K_SD: begin
        rand_ready();
        step({tag, "_memaddr"}, mk(0,0,0,0,0,0,0,0,1,2'b10,6'b0,0));
        if (kind == K_LD) begin
          mem_phase({tag, "_memread"}, wm, e_memread, e_memread, tr);
          if (tr) begin
            trap_and_reset({tag, "_memread_to"}, 3);
            return;
          end
          rand_ready();
          step({tag, "_memwb"}, mk(0,0,0,0,0,0,1,1,0,2'b00,6'b0,0));
        end else begin
          mem_phase({tag, "_memwrite"}, wm, e_memwrite, e_memwrite, tr);
          if (tr) begin
            trap_and_reset({tag, "_memwrite_to"}, 3);
            return;
          end
        end
      end
      K_R: begin
        rand_ready();
        step({tag, "_execute"}, mk(0,0,0,0,0,0,0,0,1,2'b00,{2'b10, f7, f3},0));
        rand_ready();
        step({tag, "_rwb"}, mk(0,0,0,0,0,0,1,0,0,2'b00,6'b0,0));
      end
      K_BEQ: begin
        rand_ready();
        step({tag, "_branch"}, mk(0,0,0,0,z,1,0,0,1,2'b00,6'b010000,0));
      end
      default: trap_and_reset({tag, "_illegal"}, 10);
    endcase
  endtask

  initial begin
    logic [6:0] rop;
    logic [2:0] rf3;
    logic       rf7;
    int         sel;
    int         wf;
    int         wm;
    logic [2:0] r_f3 [4];
    logic       r_f7 [4];
    r_f3 = '{3'b000, 3'b000, 3'b111, 3'b110};
    r_f7 = '{1'b0, 1'b1, 1'b0, 1'b0};

    @(posedge clk);
    #1;
    reset_seq();

    // ld with zero-wait memory: IDLE,FETCH,DECODE,MEMADDR,MEMREAD,MEMWB
    run_instr("ld", 7'b0000011, 3'b011, 1'b0, 1'b0, 0, 0);
    // R-type variants: sub, add, and, or
    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("and", 7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
    run_instr("or",  7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
    // beq taken and not taken
    run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("sd", 7'b0100011, 3'b011, 1'b0, 1'b0, 0, 3);
    // illegal instructions trap and hold the fault until reset
    run_instr("opimm", 7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("r_sll", 7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0);
    run_instr("and_f7", 7'b0110011, 3'b111, 1'b1, 1'b0, 0, 0);
    // fetch timeout, then ready on the last allowed wait cycle
    run_instr("fetch_to", 7'b0000011, 3'b011, 1'b0, 1'b0, TO + 1, 0);
    run_instr("fetch_lim", 7'b0000011, 3'b011, 1'b0, 1'b0, TO, TO);
    run_instr("memrd_to", 7'b0000011, 3'b011, 1'b0, 1'b0, 1, TO + 1);
    run_instr("memwr_to", 7'b0100011, 3'b011, 1'b0, 1'b0, 2, TO + 1);

    // sd with reset asserted during the memory wait
    i_opcode = 7'b0100011;
    i_funct3 = 3'b011;
    i_funct7b5 = 1'b0;
    i_mem_ready = 1'b1;
    step("sdrst_fetch", mk(1,0,0,1,1,0,0,0,0,2'b01,6'b0,0));
    i_mem_ready = 1'b0;
    step("sdrst_decode", mk(0,0,0,0,0,0,0,0,0,2'b10,6'b0,0));
    step("sdrst_memaddr", mk(0,0,0,0,0,0,0,0,1,2'b10,6'b0,0));
    step("sdrst_wait1", mk(1,1,1,0,0,0,0,0,0,2'b00,6'b0,0));
    step("sdrst_wait2", mk(1,1,1,0,0,0,0,0,0,2'b00,6'b0,0));
    i_rst = 1'b1;
    step("sdrst_wait3", mk(1,1,1,0,0,0,0,0,0,2'b00,6'b0,0));
    i_rst = 1'b0;
    step("sdrst_idle", '0);
    run_instr("after_rst", 7'b1100011, 3'b000, 1'b0, 1'b1, 1, 0);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      rf7 = 1'($urandom_range(0, 1));
      case (sel)
        0, 1: begin rop = 7'b0000011; rf3 = 3'b011; end
        2:    begin rop = 7'b0100011; rf3 = 3'b011; end
        3, 4, 5, 6: begin
          rop = 7'b0110011;
          wm  = $urandom_range(0, 3);
          rf3 = r_f3[wm];
          rf7 = r_f7[wm];
        end
        7, 8: begin rop = 7'b1100011; rf3 = 3'b000; end
        default: begin rop = 7'($urandom); rf3 = 3'($urandom); end
      endcase
      wf = ($urandom_range(0, 15) == 0) ? TO + 1 : $urandom_range(0, TO);
      wm = ($urandom_range(0, 15) == 0) ? TO + 1 : $urandom_range(0, TO);
      run_instr("rnd", rop, rf3, rf7, 1'($urandom_range(0, 1)), wf, wm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max cycles a memory request waits for i_mem_ready before fault; 0 disables the timeout.
REQ-002 SHALL have ports (name direction width meaning):
- i_clk in 1 clock; one clock domain, rising edge.
- i_rst in 1 reset; synchronous, active-high.
- i_opcode in 7 instruction opcode from IR; valid from DECODE onward.
- i_funct3 in 3 IR funct3.
- i_funct7b5 in 1 IR bit 30.
- i_zero in 1 ALU zero flag.
- i_mem_ready in 1 memory completes the current request this cycle.
- o_mem_req out 1 memory request; held until i_mem_ready.
- o_mem_we out 1 write request.
- o_iord out 1 address select: 0=PC, 1=ALUOut.
- o_ir_write out 1 IR load enable.
- o_pc_write out 1 PC load enable.
- o_pc_src out 1 PC source: 0=ALU result, 1=ALUOut.
- o_reg_write out 1 register-file write enable.
- o_mem_to_reg out 1 writeback select: 0=ALUOut, 1=MDR.
- o_alu_src_a out 1 A select: 0=PC, 1=rs1.
- o_alu_src_b out 2 B select: 00=rs2, 01=const 4, 10=immediate.
- o_alu_op out 6 {ALUOp[1:0], funct7b5, funct3}; ALU-control input.
- o_fault out 1 sticky fault: illegal instruction or memory timeout.

Function
REQ-003 SHALL implement FSM states IDLE, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, RWB, BRANCH, TRAP.
REQ-004 Outputs SHALL be Moore-decoded from state; exceptions: o_ir_write, o_pc_write in FETCH and o_pc_write in BRANCH. Every output not listed for a state SHALL be 0.
REQ-005 IDLE: all outputs 0; next FETCH unconditionally.
REQ-006 FETCH: mem_req=1, iord=0, src_a=0, src_b=01, alu_op=000000. On i_mem_ready: ir_write=1, pc_write=1, pc_src=0, next DECODE. Otherwise stay.
REQ-007 DECODE: src_a=0, src_b=10, alu_op=000000 (branch target into ALUOut). Next by opcode:
- 0000011 with funct3=011 (ld) -> MEMADDR.
- 0100011 with funct3=011 (sd) -> MEMADDR.
- 0110011 with (funct3,funct7b5) in {(000,0),(000,1),(111,0),(110,0)} -> EXECUTE.
- 1100011 with funct3=000 (beq) -> BRANCH.
- anything else -> TRAP.
REQ-008 MEMADDR: src_a=1, src_b=10, alu_op=000000. Next MEMREAD for ld, MEMWRITE for sd.
REQ-009 MEMREAD: mem_req=1, iord=1; on i_mem_ready -> MEMWB.
REQ-010 MEMWB: reg_write=1, mem_to_reg=1; next FETCH.
REQ-011 MEMWRITE: mem_req=1, mem_we=1, iord=1; on i_mem_ready -> FETCH.
REQ-012 EXECUTE: src_a=1, src_b=00, alu_op={10, i_funct7b5, i_funct3}; next RWB.
REQ-013 RWB: reg_write=1, mem_to_reg=0; next FETCH.
REQ-014 BRANCH: src_a=1, src_b=00, alu_op=010000, pc_src=1, pc_write=i_zero; next FETCH.
REQ-015 TRAP: all outputs 0 except o_fault=1. Exit only by reset.
REQ-016 Cycles per instruction with zero-wait memory: ld 5, sd 4, R-type 4, beq 3.
REQ-017 A wait counter SHALL clear on entry to any mem_req state and increment each cycle with mem_req=1 and i_mem_ready=0.
REQ-018 When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to TRAP next cycle. i_mem_ready in that same cycle wins; no fault is raised.
REQ-019 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1, and it SHALL saturate (never wrap).

Reset
REQ-020 i_rst=1 at a clock edge SHALL force state IDLE, clear the wait counter and clear o_fault, from any state, including mid-request.
REQ-021 During and immediately after reset, all outputs SHALL be 0. The first FETCH occurs 1 cycle after reset deasserts.

Structure
REQ-022 A shared package SHALL hold:
- state enum;
- opcode constants (LD, SD, RTYPE, BEQ);
- ALUOp constants (00 mem, 01 branch, 10 R-type);
- src_b select constants.
REQ-023 Opcode/funct legality and next-state decode SHALL be one combinational sub-module, control_decode; the FSM, counter and output decode live in the top.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset then ld (0000011/011), ready=1 always -> states IDLE,FETCH,DECODE,MEMADDR,MEMREAD,MEMWB; reg_write=1 with mem_to_reg=1 in cycle 6.
- R-type sub (funct3=000, funct7b5=1) -> o_alu_op=101000 in EXECUTE; add gives 100000, and 100111, or 100110.
- beq with i_zero=1 -> pc_write=1, pc_src=1 in BRANCH. Same with i_zero=0 -> pc_write=0; next FETCH either way.
- Opcode 0010011 or R-type funct3=001 -> TRAP after DECODE; o_fault=1 held 10 cycles; i_rst clears it and returns to IDLE.
- TIMEOUT_CYCLES=4, i_mem_ready=0 in FETCH -> TRAP. i_mem_ready rising on the 4th wait cycle -> DECODE, o_fault=0.
- sd with 3 wait cycles -> mem_req=mem_we=iord=1 stable all 4 cycles; i_rst asserted mid-wait -> IDLE with all outputs 0 on the next cycle.
